// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce array: per-channel FSM states and the
// microsecond-to-clock-cycle conversion used to size the timers.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } db_state_e;

  // 64-bit intermediate: long hold times at high clock rates overflow 32 bits.
  function automatic int us_to_cycles(input longint clk_hz, input longint time_us);
    longint l_cycles;
    l_cycles = (clk_hz * time_us) / 64'sd1000000;
    return int'(l_cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: input synchroniser, 4-state debounce FSM, edge pulses
// and a saturating hold timer that fires a single long-press pulse.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES   = 100,
  parameter int LONG_CYCLES = 500,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  db_state_e              r_state;
  db_state_e              w_state_nxt;
  logic [DB_W-1:0]        r_db_cnt;
  logic [DB_W-1:0]        w_db_cnt_nxt;
  logic                   w_level_nxt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_long;
  logic [LONG_W-1:0]      r_hold;

  // Input synchroniser chain
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // FSM state and stability counter
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state  <= ST_LOW;
      r_db_cnt <= {DB_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_db_cnt <= w_db_cnt_nxt;
    end
  end

  // Next state: a WAIT state commits on the edge its counter would reach DB_CYCLES
  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    case (r_state)
      ST_LOW: begin
        if (w_s) begin
          w_state_nxt  = ST_WAIT_HIGH;
          w_db_cnt_nxt = {DB_W{1'b0}};
        end else begin
          w_state_nxt  = ST_LOW;
        end
      end
      ST_WAIT_HIGH: begin
        if (!w_s) begin
          w_state_nxt  = ST_LOW;
          w_db_cnt_nxt = {DB_W{1'b0}};
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt  = ST_HIGH;
          w_db_cnt_nxt = {DB_W{1'b0}};
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_W'(1);
        end
      end
      ST_HIGH: begin
        if (!w_s) begin
          w_state_nxt  = ST_WAIT_LOW;
          w_db_cnt_nxt = {DB_W{1'b0}};
        end else begin
          w_state_nxt  = ST_HIGH;
        end
      end
      ST_WAIT_LOW: begin
        if (w_s) begin
          w_state_nxt  = ST_HIGH;
          w_db_cnt_nxt = {DB_W{1'b0}};
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt  = ST_LOW;
          w_db_cnt_nxt = {DB_W{1'b0}};
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_W'(1);
        end
      end
      default: begin
        w_state_nxt  = ST_LOW;
        w_db_cnt_nxt = {DB_W{1'b0}};
      end
    endcase
  end

  assign w_level_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_WAIT_LOW);

  // Registered level and edge pulses, aligned to the first cycle of the new level
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_rise  <= w_level_nxt & ~r_level;
      r_fall  <= ~w_level_nxt & r_level;
    end
  end

  // Hold timer: restarts only on a rise, so WAIT_LOW bounces keep accumulated time
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_hold <= {LONG_W{1'b0}};
      r_long <= 1'b0;
    end else if (w_level_nxt && !r_level) begin
      r_hold <= {LONG_W{1'b0}};
      r_long <= 1'b0;
    end else if (r_level && (r_hold != LONG_MAX)) begin
      r_hold <= r_hold + LONG_W'(1);
      r_long <= (r_hold == (LONG_MAX - LONG_W'(1)));
    end else begin
      r_long <= 1'b0;
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign long_o  = r_long;

endmodule

// File: rtl/debounce_array.sv
// Array of independent debounced button channels with edge and long-press
// pulses; timing parameters are given in microseconds and converted here.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int DB_TIME_US   = 5,
  parameter int LONG_TIME_US = 500_000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] long_o
);

  localparam int DB_CYCLES   = us_to_cycles(longint'(CLK_FREQ_HZ), longint'(DB_TIME_US));
  localparam int LONG_CYCLES = us_to_cycles(longint'(CLK_FREQ_HZ), longint'(LONG_TIME_US));

  if ((DB_CYCLES < 1) || (LONG_CYCLES <= DB_CYCLES) || (N_CH < 1) || (N_CH > 32) ||
      (SYNC_STAGES < 2)) begin : g_bad_params
    $fatal(1, "debounce_array: invalid timing or size parameters");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_channel (
      .clk    (clk),
      .reset_n(reset_n),
      .btn_i  (btn_i[g]),
      .level_o(level_o[g]),
      .rise_o (rise_o[g]),
      .fall_o (fall_o[g]),
      .long_o (long_o[g])
    );
  end

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench for debounce_array: expected pulses are queued with their
// cycle when stimulus is driven and matched on every falling clock edge.
module tb_debounce_array;

  localparam int N_CH = 4;
  localparam int SYNC = 2;
  localparam int DB   = 100;
  localparam int LONG = 500;
  localparam int LAT  = SYNC + DB + 1;  // drive at negedge n -> pulse seen at negedge n+LAT

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_LONG = 2;

  typedef struct {
    int         kind;
    logic [3:0] mask;
    int         at;
  } ev_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic [N_CH-1:0] long_o;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  ev_t        sb_q[$];
  logic [3:0] lvl_model = 4'h0;

  debounce_array #(
    .N_CH        (N_CH),
    .CLK_FREQ_HZ (100_000_000),
    .DB_TIME_US  (1),
    .LONG_TIME_US(5),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_i  (btn),
    .level_o(level_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .long_o (long_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] mask, input int at);
    ev_t e;
    e.kind = kind;
    e.mask = mask;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: gather this cycle's expected pulses and compare against the DUT
  initial begin
    logic [3:0] e_rise;
    logic [3:0] e_fall;
    logic [3:0] e_long;
    forever begin
      @(negedge clk);
      e_rise = 4'h0;
      e_fall = 4'h0;
      e_long = 4'h0;
      while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
        if (sb_q[0].at < cyc) check_eq("stale_event", 32'(sb_q[0].at), 32'(cyc));
        else if (sb_q[0].kind == K_RISE) e_rise = e_rise | sb_q[0].mask;
        else if (sb_q[0].kind == K_FALL) e_fall = e_fall | sb_q[0].mask;
        else e_long = e_long | sb_q[0].mask;
        void'(sb_q.pop_front());
      end
      if ((e_rise | rise_o) != 4'h0) check_eq("rise_o", 32'(rise_o), 32'(e_rise));
      if ((e_fall | fall_o) != 4'h0) check_eq("fall_o", 32'(fall_o), 32'(e_fall));
      if ((e_long | long_o) != 4'h0) check_eq("long_o", 32'(long_o), 32'(e_long));
      if ((e_rise | e_fall | rise_o | fall_o) != 4'h0) begin
        lvl_model = (lvl_model | e_rise) & ~e_fall;
        check_eq("level_at_edge", 32'(level_o), 32'(lvl_model));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;
    reset_n = 1'b1;
    btn     = 4'hF;

    // Reset held with buttons pressed: everything stays zero
    @(negedge clk);
    check_eq("rst_outs", 32'({level_o, rise_o, fall_o, long_o}), 32'h0);
    repeat (2) @(negedge clk);
    check_eq("rst_outs_end", 32'({level_o, rise_o, fall_o, long_o}), 32'h0);
    reset_n = 1'b0;
    n = cyc;
    push(K_RISE, 4'hF, n + LAT);
    @(negedge clk);
    check_eq("post_rst_pulses", 32'({rise_o, fall_o, long_o}), 32'h0);
    go_to(n + LAT + 5);
    check_eq("lvl_all_high", 32'(level_o), 32'hF);

    // Release everything well before the long-press time
    btn = 4'h0;
    n = cyc;
    push(K_FALL, 4'hF, n + LAT);
    go_to(n + LAT + 10);
    check_eq("lvl_all_low", 32'(level_o), 32'h0);

    // Bounce on ch0, then hold; ch3 pressed shortly after
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      repeat (2) @(negedge clk);
    end
    check_eq("bounce_no_level", 32'(level_o), 32'h0);
    btn[0] = 1'b1;
    n = cyc;
    push(K_RISE, 4'b0001, n + LAT);
    repeat (2) @(negedge clk);
    btn[3] = 1'b1;
    push(K_RISE, 4'b1000, cyc + LAT);
    go_to(n + LAT + 10);
    check_eq("lvl_ch0_ch3", 32'(level_o), 32'h9);

    // Simultaneous release of ch0 and ch3
    btn[0] = 1'b0;
    btn[3] = 1'b0;
    n = cyc;
    push(K_FALL, 4'b1001, n + LAT);
    go_to(n + LAT + 10);
    check_eq("lvl_after_simul", 32'(level_o), 32'h0);

    // Long press on ch1 for 700 cycles
    btn[1] = 1'b1;
    n = cyc;
    push(K_RISE, 4'b0010, n + LAT);
    push(K_LONG, 4'b0010, n + LAT + LONG);
    go_to(n + 700);
    check_eq("lvl_long_held", 32'(level_o), 32'h2);
    btn[1] = 1'b0;
    m = cyc;
    push(K_FALL, 4'b0010, m + LAT);
    go_to(m + LAT + 10);

    // Short press on ch2: no long pulse
    btn[2] = 1'b1;
    n = cyc;
    push(K_RISE, 4'b0100, n + LAT);
    go_to(n + 300);
    btn[2] = 1'b0;
    push(K_FALL, 4'b0100, cyc + LAT);
    go_to(n + 700);
    check_eq("lvl_after_short", 32'(level_o), 32'h0);

    // Reset in the middle of a ch1 hold
    btn[1] = 1'b1;
    n = cyc;
    push(K_RISE, 4'b0010, n + LAT);
    go_to(n + LAT + 400);
    check_eq("lvl_before_rst", 32'(level_o), 32'h2);
    #2;
    reset_n = 1'b1;
    #1;
    check_eq("async_rst_clear", 32'({level_o, rise_o, fall_o, long_o}), 32'h0);
    lvl_model = 4'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    m = cyc;
    push(K_RISE, 4'b0010, m + LAT);
    push(K_LONG, 4'b0010, m + LAT + LONG);
    go_to(m + 700);
    btn[1] = 1'b0;
    n = cyc;
    push(K_FALL, 4'b0010, n + LAT);
    go_to(n + LAT + 10);

    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    check_eq("final_level", 32'(level_o), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_array.md
DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, number of independent button channels (1..32).
REQ-002 The block SHALL have parameter CLK_FREQ_HZ, default 100_000_000, clk frequency.
REQ-003 The block SHALL have parameter DB_TIME_US, default 5, required input stability time in microseconds.
REQ-004 The block SHALL have parameter LONG_TIME_US, default 500_000, hold time before a long-press pulse.
REQ-005 The block SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-006 The block SHALL have port clk  input  1  rising-edge clock.
REQ-007 The block SHALL have port reset_n  input  1  reset; asynchronous, active-high.
REQ-008 The block SHALL have port btn_i  input  N_CH  raw asynchronous button inputs.
REQ-009 The block SHALL have port level_o  output  N_CH  debounced level per channel.
REQ-010 The block SHALL have port rise_o  output  N_CH  one-cycle pulse on debounced 0->1.
REQ-011 The block SHALL have port fall_o  output  N_CH  one-cycle pulse on debounced 1->0.
REQ-012 The block SHALL have port long_o  output  N_CH  one-cycle pulse when held for LONG_TIME_US.

Function
REQ-013 Derived constants SHALL be DB_CYCLES = CLK_FREQ_HZ*DB_TIME_US/1_000_000 and LONG_CYCLES = CLK_FREQ_HZ*LONG_TIME_US/1_000_000, computed by integer arithmetic at elaboration; DB_CYCLES >= 1 and LONG_CYCLES > DB_CYCLES, otherwise elaboration fails.
REQ-014 Each btn_i bit SHALL pass through a SYNC_STAGES flop chain; only the last stage (s) feeds the channel logic.
REQ-015 Each channel SHALL run a 4-state FSM: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-016 LOW: s=1 -> WAIT_HIGH with counter cleared; otherwise stay.
REQ-017 WAIT_HIGH: s=0 -> LOW (bounce, counter cleared); s=1 increments counter; on the edge where counter would reach DB_CYCLES -> HIGH.
REQ-018 HIGH and WAIT_LOW SHALL mirror LOW and WAIT_HIGH with polarity inverted.
REQ-019 level_o SHALL be 1 exactly in HIGH and WAIT_LOW.
REQ-020 rise_o/fall_o SHALL be registered and high for exactly the one cycle in which level_o first shows the new value.
REQ-021 Latency: btn_i stable from edge k -> level_o changes after edge k+SYNC_STAGES+DB_CYCLES (+/-1 for asynchronous sampling).
REQ-022 A glitch shorter than DB_CYCLES cycles after synchronisation SHALL produce no level_o, rise_o or fall_o change.
REQ-023 A hold counter SHALL clear on rise and increment each cycle in HIGH or WAIT_LOW, saturating at LONG_CYCLES; long_o pulses once, on the cycle the count reaches LONG_CYCLES.
REQ-024 long_o SHALL not repeat until a new rise; a release before LONG_CYCLES produces no long_o.
REQ-025 WAIT_LOW bounce back to HIGH SHALL not clear the hold counter.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-027 Counter widths SHALL be $clog2(DB_CYCLES+1) and $clog2(LONG_CYCLES+1); no wrap-around is permitted.

Reset
REQ-028 While reset_n=1 all synchroniser flops, FSMs (LOW), counters and outputs SHALL be 0, taking effect without a clock edge.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard progress; after release a held button re-qualifies from LOW with full DB_CYCLES and produces rise_o.
REQ-030 No output SHALL pulse in the first cycle after reset release.

Structure
REQ-031 A shared package debounce_pkg SHALL hold the FSM state enum and the cycle-count calculation function.
REQ-032 Per-channel logic SHALL be a sub-module debounce_channel, instantiated N_CH times by generate loop; the synchroniser belongs inside it.

Verification (N_CH=4, CLK_FREQ_HZ=100_000_000, DB_TIME_US=1 -> DB_CYCLES=100, LONG_TIME_US=5 -> LONG_CYCLES=500)
REQ-033 Reset: reset_n=1 for 3 cycles with btn_i=4'hF -> all outputs 0; held btn_i=4'hF after release -> rise_o=4'hF once, ~102 cycles later.
REQ-034 Bounce: ch0 toggled every 2 cycles, 10 times, then held 1 -> no output change during toggling; level_o[0]=1 with one rise_o[0] pulse ~102 cycles after the final rising edge.
REQ-035 Long press: ch1 held 700 cycles -> one rise_o[1], one long_o[1] 500 cycles after rise_o[1], no second long_o.
REQ-036 Short press: ch2 held 300 cycles then released -> rise_o[2], fall_o[2] after release+~102 cycles, long_o[2] never asserted.
REQ-037 Simultaneous: ch0 and ch3 released on the same edge -> fall_o=4'b1001 in a single cycle.
REQ-038 Reset mid-hold: ch1 held, reset_n pulsed 400 cycles after rise -> outputs clear; rise_o[1] again ~102 cycles after release; long_o[1] 500 cycles after that.
